// File: rtl/demux_router.sv
// ============================================================================
// Module   : demux_router
// Brief    : Registered 1-to-CHANNELS stream router with broadcast mode and
//            one-entry per-channel output registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module demux_router #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 8,
    parameter int SEL_W     = 3,
    parameter int HOLD_LAST = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_in_valid,
    output logic                      o_in_ready,
    input  logic [WIDTH-1:0]          i_data_in,
    input  logic [SEL_W-1:0]          i_select,
    input  logic                      i_bcast,
    output logic [CHANNELS*WIDTH-1:0] o_out_data,
    output logic [CHANNELS-1:0]       o_out_valid,
    input  logic [CHANNELS-1:0]       i_out_ready,
    output logic                      o_sel_err,
    input  logic                      i_err_clr
);

    localparam logic [SEL_W:0] c_CHAN = (SEL_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0] r_valid;
    logic [WIDTH-1:0]    r_data [CHANNELS];
    logic                r_sel_err;

    logic [CHANNELS-1:0] w_free;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_load;
    logic                w_in_range;
    logic                w_free_sel;
    logic                w_xfer;
    logic                w_drop;

    // A slot can take a word when empty or when its current word leaves this cycle.
    assign w_free     = ~r_valid | i_out_ready;
    assign w_in_range = ({1'b0, i_select} < c_CHAN);
    assign w_free_sel = |(w_hit & w_free);

    assign o_in_ready = i_bcast    ? (&w_free) :
                        w_in_range ? w_free_sel : 1'b1;

    assign w_xfer = i_in_valid & o_in_ready;
    assign w_drop = w_xfer & ~i_bcast & ~w_in_range;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            localparam logic [SEL_W-1:0] c_IDX = SEL_W'(c);
            assign w_hit[c]  = (i_select == c_IDX);
            assign w_load[c] = w_xfer & (i_bcast | w_hit[c]);
            assign o_out_data[c*WIDTH +: WIDTH] = r_data[c];
        end
    endgenerate

    // Load takes priority over drain, so a simultaneous drain+load keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                r_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_load[c]) begin
                    r_valid[c] <= 1'b1;
                    r_data[c]  <= i_data_in;
                end else if (r_valid[c] && i_out_ready[c]) begin
                    r_valid[c] <= 1'b0;
                    if (HOLD_LAST == 0) begin
                        r_data[c] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_drop) begin
            r_sel_err <= 1'b1;
        end else if (i_err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

    assign o_out_valid = r_valid;
    assign o_sel_err   = r_sel_err;

endmodule

`default_nettype wire

// File: doc/demux_router.md
Name: demux_router

Overview:
- Parametrised, registered successor of the processor's 8-way combinational demux.
- Routes a single valid/ready input stream to one of CHANNELS output channels, or to all of them in broadcast mode.
- Each channel has a one-entry output register with its own valid/ready handshake, so a stalled consumer blocks only the traffic addressed to it.
- Sits between the decode stage and the register-file, ALU and I/O write ports.

Parameters:
- WIDTH, 8: data width per channel.
- CHANNELS, 8: number of output channels; legal range 2..16, not required to be a power of two.
- SEL_W, 3: select width; must satisfy 2**SEL_W >= CHANNELS.
- HOLD_LAST, 0: 0 means a channel's out_data reads all-zero whenever its out_valid is 0. 1 means a channel's out_data holds its last delivered word.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle.
- data_in  in  WIDTH  input word.
- select  in  SEL_W  destination channel index.
- bcast  in  1  deliver data_in to every channel; select is ignored.
- out_data  out  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  out  CHANNELS  per-channel valid.
- out_ready  in  CHANNELS  per-channel consumer ready.
- sel_err  out  1  sticky flag: an out-of-range select was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Reset (asynchronous, active-low): all out_valid = 0, all out_data = 0, sel_err = 0. Behaviour is identical on assertion at any time, including mid-transfer: every held word is discarded.
- Slot i is free when !out_valid[i] || out_ready[i]. This is a pass-through ready path, which sustains one word per cycle per channel.
- in_ready is combinational:
  - bcast = 1: the AND of free over all channels.
  - bcast = 0, select < CHANNELS: free[select].
  - bcast = 0, select >= CHANNELS: 1.
- A transfer occurs when in_valid && in_ready at the rising edge.
- On a transfer to channel i (or to every channel when bcast = 1):
  - out_data[i] <= data_in and out_valid[i] <= 1.
  - Latency is 1 cycle: the word is visible on the next cycle.
- Drain: if out_valid[i] && out_ready[i] and there is no new transfer to i on that edge, out_valid[i] <= 0. With HOLD_LAST = 0, out_data[i] <= 0 on the same edge.
- Simultaneous drain and load on channel i in the same cycle: the new word replaces the old one and out_valid[i] stays 1. No bubble and no loss.
- Non-addressed channels are unaffected by a transfer.
- Broadcast is atomic: either every channel loads on the same edge or none does. There are never partial broadcasts.
- Out-of-range select (non-bcast) on a transfer:
  - The word is consumed and dropped; no out_valid changes.
  - sel_err <= 1.
- err_clr: sel_err <= 0 on the next edge. If err_clr and a new out-of-range transfer occur in the same cycle, set wins.
- in_valid = 0: no state change apart from drains. data_in, select and bcast are don't-care.
- A held word is never lost or duplicated: each accepted word appears exactly once per destination channel.
- No combinational path exists from data_in to out_data.

Test Plan:
1. Reset, then stream select = 0..7 with data = 8'h10+i, all out_ready = 1 → each out_valid[i] pulses for exactly one cycle, one cycle after acceptance, with out_data[i] = 8'h10+i. Other channels read 0 (HOLD_LAST = 0).
2. Hold out_ready[3] = 0 and send two words to ch3 (8'hA1, 8'hA2) → A1 is held and in_ready = 0 while select = 3. A word sent to ch5 in the same period is accepted and delivered. Raising out_ready[3] drains A1 and A2 is accepted on that same edge; out_valid[3] stays 1 with 8'hA2.
3. bcast = 1, data = 8'h5A, with out_ready[6] = 0 and ch6 full → in_ready = 0 and no channel loads. Release ch6 → all 8 channels show 8'h5A on the same cycle.
4. CHANNELS = 5, select = 6, in_valid = 1 → in_ready = 1, the word is dropped, no out_valid rises, and sel_err = 1 from the next cycle. Assert err_clr → sel_err = 0.
5. Assert rst_n = 0 mid-stream with ch2 and ch4 holding words → out_valid drops to 0 immediately, without waiting for clk, and all out_data = 0.
6. HOLD_LAST = 1: deliver 8'hC3 to ch1, then drain it → out_valid[1] = 0 and out_data[1] remains 8'hC3.
